instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//   Inverse of the main decoder: packs instruction fields into 32-bit MIPS words for the supported
//   op set (R-type add/sub/and/or/slt, LW, SW, BEQ, BNE, ADDI, J, ORI, ANDI).
//   Streams encoded words, with word addresses, to the instruction-memory loader / testbench program builder.
//   Valid/ready on both sides; DEPTH-entry output FIFO absorbs backpressure; illegal ops are flagged and dropped.
// PARAMETERS
//   DEPTH      2        output FIFO entries (power of 2, >=2)
//   ADDR_W     32       width of out_addr (byte address)
//   BASE_ADDR  0        byte address of first emitted word
//   CNT_W      8        width of illegal_cnt
// PORTS
//   clk          in   1       clock, rising edge
//   reset        in   1       synchronous, active-high
//   in_valid     in   1       field bundle valid
//   in_ready     out  1       encoder can accept (FIFO not full)
//   in_op        in   6       opcode
//   in_rs/in_rt/in_rd in 5 each  register fields
//   in_shamt     in   5       shift amount (R-type)
//   in_funct     in   6       function field (R-type)
//   in_imm       in   16      immediate (I-type)
//   in_target    in   26      jump target (J-type)
//   out_valid    out  1       encoded word available
//   out_ready    in   1       sink accepts word
//   out_instr    out  32      encoded instruction
//   out_addr     out  ADDR_W  byte address of out_instr
//   err          out  1       sticky: an illegal op/funct was accepted
//   illegal_cnt  out  CNT_W   count of dropped bundles, saturating at all-ones
// BEHAVIOUR
//   Reset: in_ready=1, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, illegal_cnt=0, FIFO empty.
//   Accept = in_valid & in_ready; emit = out_valid & out_ready. in_ready = !full (from registered count).
//   Encoding: R (op 000000): {op,rs,rt,rd,shamt,funct}; legal funct 100000,100010,100100,100101,101010.
//     I (100011,101011,000100,000101,001000,001101,001100): {op,rs,rt,imm}. J (000010): {op,target}.
//   Any other op, or R-type with other funct: illegal -> bundle still accepted (handshake completes),
//     nothing pushed, err<=1, illegal_cnt+=1 (saturating). Clears only on reset.
//   Latency: legal bundle accepted in cycle N into empty FIFO -> out_valid=1 with its word in cycle N+1.
//   Order preserved; out_instr/out_addr stable while out_valid & !out_ready.
//   out_addr: word address counter; presents addr of FIFO head; +4 per emit; wraps mod 2^ADDR_W.
//     Illegal bundles consume no address.
//   Full: in_ready=0; emit in the same cycle does not enable accept; in_ready returns next cycle.
//   Empty: out_valid=0; push and emit cannot coincide on the same entry.
//   Simultaneous accept+emit when neither full nor empty: count unchanged, both pointers advance.
//   Reset mid-operation: FIFO flushed (pending words lost), address back to BASE_ADDR, flags cleared.
// TESTING
//   add $3,$1,$2 (op0 rs1 rt2 rd3 sh0 fn100000) after reset -> next cycle out_instr=0x00221820, out_addr=0x0.
//   lw $8,4($29) then beq $1,$2,-1 (imm 0xFFFF) -> 0x8FA80004 @0x0, 0x1022FFFF @0x4.
//   j target 0x0000010 -> out_instr=0x08000010; ori rt2 rs0 imm 0x00FF -> 0x340200FF.
//   op 0x3F, then R-type funct 000000 -> no out_valid, err=1, illegal_cnt=2, in_ready stays 1, addr unchanged.
//   out_ready=0, push 3 legal words -> in_ready=0 after 2; release -> 3 words in order @0x0,0x4,0x8.
//   FIFO full, reset for 1 cycle -> out_valid=0, out_addr=BASE_ADDR, err=0; next add emits @BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-bundle input and encoded-word output handshakes of instr_encoder
//   master: producer/sink side (drives in_* and out_ready)
//   slave:  encoder side (drives in_ready and out_*)
interface instr_encoder_if #(parameter int ADDR_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  modport master(
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );
  modport slave(
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs MIPS instruction fields into 32-bit words and streams them with byte addresses
//   clk, reset        clock and synchronous active-high reset
//   bus (slave)       in_* field bundle valid/ready, out_* word/address valid/ready
//   err               sticky flag: an illegal op/funct bundle was accepted
//   illegal_cnt       saturating count of dropped illegal bundles
module instr_encoder #(
  parameter int                DEPTH     = 2,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  instr_encoder_if.slave   bus,
  output logic             err,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       word;
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  ill_q, ill_d;
  logic              is_r, is_i, is_j, legal, accept, push, pop;
  always_comb begin
    is_r   = bus.in_op == 6'b000000;
    is_j   = bus.in_op == 6'b000010;
    is_i   = bus.in_op inside {6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b001101, 6'b001100};
    legal  = is_r ? bus.in_funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010} : is_i | is_j;
    word   = is_r ? {bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct}
           : is_j ? {bus.in_op, bus.in_target}
           : {bus.in_op, bus.in_rs, bus.in_rt, bus.in_imm};
    accept = bus.in_valid & bus.in_ready;
    // illegal bundles complete the handshake but never reach the FIFO
    push   = accept & legal;
    pop    = bus.out_valid & bus.out_ready;
    wr_d   = push ? wr_q + PW'(1) : wr_q;
    rd_d   = pop ? rd_q + PW'(1) : rd_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    addr_d = pop ? addr_q + ADDR_W'(4) : addr_q;
    err_d  = err_q | (accept & ~legal);
    ill_d  = (accept & ~legal & ~&ill_q) ? ill_q + CNT_W'(1) : ill_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
      ill_q  <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      err_q  <= err_d;
      ill_q  <= ill_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= word;
  end
  assign bus.in_ready  = cnt_q != CW'(DEPTH);
  assign bus.out_valid = cnt_q != '0;
  assign bus.out_instr = bus.out_valid ? mem_q[rd_q] : '0;
  assign bus.out_addr  = addr_q;
  assign err           = err_q;
  assign illegal_cnt   = ill_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a queue-based reference model
module tb_instr_encoder;
  localparam int DEPTH = 2;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       err;
  logic [7:0] illegal_cnt;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [31:0] q[$];
  logic [31:0] m_addr = 32'h0;
  logic        m_err = 1'b0;
  int          m_cnt = 0;
  logic [5:0]  legal_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [5:0]  legal_op [8] = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h0C, 6'h02};
  always #5 clk = ~clk;
  instr_encoder_if #(.ADDR_W(32)) ifc();
  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h0), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(ifc), .err(err), .illegal_cnt(illegal_cnt)
  );
  function automatic bit m_legal(input logic [5:0] op, input logic [5:0] fn);
    bit ok = 0;
    if (op == 6'h00) begin
      foreach (legal_fn[k]) if (legal_fn[k] == fn) ok = 1;
    end else begin
      foreach (legal_op[k]) if (legal_op[k] == op) ok = 1;
    end
    return ok;
  endfunction
  function automatic logic [31:0] m_enc();
    int unsigned w;
    w = int'(ifc.in_op) * (1 << 26);
    if (ifc.in_op == 6'h00)
      w += ifc.in_rs * (1 << 21) + ifc.in_rt * (1 << 16) + ifc.in_rd * (1 << 11) + ifc.in_shamt * 64 + ifc.in_funct;
    else if (ifc.in_op == 6'h02)
      w += ifc.in_target;
    else
      w += ifc.in_rs * (1 << 21) + ifc.in_rt * (1 << 16) + ifc.in_imm;
    return w;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("in_ready", 32'(ifc.in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(ifc.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk("out_instr", ifc.out_instr, q[0]);
    chk("out_addr", ifc.out_addr, m_addr);
    chk("err", 32'(err), 32'(m_err));
    chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
  endtask
  task automatic tick();
    bit acc, emi;
    acc = ifc.in_valid && q.size() < DEPTH;
    emi = q.size() > 0 && ifc.out_ready;
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_addr = 0;
      m_err = 0;
      m_cnt = 0;
    end else begin
      if (emi) begin
        void'(q.pop_front());
        m_addr += 4;
      end
      if (acc) begin
        if (m_legal(ifc.in_op, ifc.in_funct)) q.push_back(m_enc());
        else begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask
  task automatic put(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tg);
    ifc.in_valid = 1'b1;
    ifc.in_op = op;
    ifc.in_rs = rs;
    ifc.in_rt = rt;
    ifc.in_rd = rd;
    ifc.in_shamt = sh;
    ifc.in_funct = fn;
    ifc.in_imm = imm;
    ifc.in_target = tg;
  endtask
  task automatic do_reset();
    ifc.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    ifc.out_ready = 1'b1;
    put(6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0);
    ifc.in_valid = 1'b0;
    tick();
    tick();
    chk("reset_out_instr", ifc.out_instr, 32'h0);
    chk("reset_in_ready", 32'(ifc.in_ready), 32'h1);
    reset = 1'b0;
    put(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    tick();
    ifc.in_valid = 1'b0;
    chk("add_word", ifc.out_instr, 32'h00221820);
    chk("add_addr", ifc.out_addr, 32'h0);
    tick();
    do_reset();
    ifc.out_ready = 1'b0;
    put(6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 26'h0);
    tick();
    chk("lw_word", ifc.out_instr, 32'h8FA80004);
    put(6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'hFFFF, 26'h0);
    tick();
    ifc.in_valid = 1'b0;
    chk("lw_held", ifc.out_instr, 32'h8FA80004);
    ifc.out_ready = 1'b1;
    tick();
    chk("beq_word", ifc.out_instr, 32'h1022FFFF);
    chk("beq_addr", ifc.out_addr, 32'h4);
    tick();
    do_reset();
    put(6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0000010);
    tick();
    chk("j_word", ifc.out_instr, 32'h08000010);
    put(6'h0D, 5'd0, 5'd2, 5'd0, 5'd0, 6'h00, 16'h00FF, 26'h0);
    tick();
    ifc.in_valid = 1'b0;
    chk("ori_word", ifc.out_instr, 32'h340200FF);
    tick();
    do_reset();
    put(6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h1234, 26'h0);
    tick();
    put(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h00, 16'h0, 26'h0);
    tick();
    ifc.in_valid = 1'b0;
    chk("illegal_valid", 32'(ifc.out_valid), 32'h0);
    chk("illegal_err", 32'(err), 32'h1);
    chk("illegal_cnt2", 32'(illegal_cnt), 32'h2);
    chk("illegal_ready", 32'(ifc.in_ready), 32'h1);
    chk("illegal_addr", ifc.out_addr, 32'h0);
    do_reset();
    ifc.out_ready = 1'b0;
    put(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    tick();
    put(6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 26'h0);
    tick();
    chk("full_ready", 32'(ifc.in_ready), 32'h0);
    put(6'h04, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'hFFFF, 26'h0);
    ifc.out_ready = 1'b1;
    tick();
    chk("bp_w1", ifc.out_instr, 32'h8FA80004);
    chk("bp_a1", ifc.out_addr, 32'h4);
    chk("bp_ready_back", 32'(ifc.in_ready), 32'h1);
    tick();
    ifc.in_valid = 1'b0;
    chk("bp_w2", ifc.out_instr, 32'h1022FFFF);
    chk("bp_a2", ifc.out_addr, 32'h8);
    tick();
    chk("bp_drained", 32'(ifc.out_valid), 32'h0);
    do_reset();
    ifc.out_ready = 1'b0;
    put(6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0);
    tick();
    put(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    tick();
    tick();
    put(6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 26'h0);
    tick();
    chk("pre_rst_err", 32'(err), 32'h1);
    do_reset();
    chk("rst_valid", 32'(ifc.out_valid), 32'h0);
    chk("rst_addr", ifc.out_addr, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    ifc.out_ready = 1'b1;
    put(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    tick();
    ifc.in_valid = 1'b0;
    chk("post_rst_word", ifc.out_instr, 32'h00221820);
    chk("post_rst_addr", ifc.out_addr, 32'h0);
    tick();
    put(6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0);
    for (int k = 0; k < 260; k++) tick();
    ifc.in_valid = 1'b0;
    chk("sat_cnt", 32'(illegal_cnt), 32'hFF);
    for (int k = 0; k < 1500; k++) begin
      int r;
      reset = $urandom_range(0, 199) == 0;
      ifc.in_valid = $urandom_range(0, 2) != 0;
      ifc.out_ready = $urandom_range(0, 3) != 0;
      ifc.in_rs = 5'($urandom);
      ifc.in_rt = 5'($urandom);
      ifc.in_rd = 5'($urandom);
      ifc.in_shamt = 5'($urandom);
      ifc.in_imm = 16'($urandom);
      ifc.in_target = 26'($urandom);
      ifc.in_funct = 6'($urandom);
      r = $urandom_range(0, 9);
      if (r < 4) begin
        ifc.in_op = 6'h00;
        if ($urandom_range(0, 4) != 0) ifc.in_funct = legal_fn[$urandom_range(0, 4)];
      end else if (r < 9) ifc.in_op = legal_op[$urandom_range(0, 7)];
      else ifc.in_op = 6'($urandom);
      tick();
    end
    reset = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    tick();
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
